// File: rtl/bcd_n_digitos.sv
// bcd_n_digitos
// Sequential binary-to-BCD converter (double dabble, one bit per clock).
// A start request in OCIOSO captures the input value. Each following edge in
// CONVERTE shifts one magnitude bit, MSB first, into the working BCD register.
// The edge that leaves CONCLUI publishes the result and pulses pronto.
//
// Parameters
//   LARGURA   width of numero (2..64)
//   DIGITOS   number of BCD output digits (1..20)
//   COM_SINAL 1: numero is two's complement, 0: numero is unsigned
//
// Ports
//   clock    rising-edge clock
//   reset    asynchronous active-low reset
//   iniciar  start request, accepted only in OCIOSO
//   numero   value to convert, captured on the accepting edge
//   ocupado  high while CONVERTE or CONCLUI
//   pronto   one-cycle pulse when a new result is published
//   sinal    sign of the last converted value (1 = negative)
//   digitos  BCD result, digit 0 (units) in bits [3:0]
//   estouro  magnitude of the last value did not fit in DIGITOS digits
module bcd_n_digitos #(
  parameter int LARGURA   = 32,
  parameter int DIGITOS   = 10,
  parameter int COM_SINAL = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   iniciar,
  input  logic [LARGURA-1:0]     numero,
  output logic                   ocupado,
  output logic                   pronto,
  output logic                   sinal,
  output logic [4*DIGITOS-1:0]   digitos,
  output logic                   estouro
);

  localparam int CW = $clog2(LARGURA + 1);
  localparam int BW = 4 * DIGITOS;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    CONVERTE = 2'd1,
    CONCLUI  = 2'd2
  } estado_t;

  // One double-dabble step: correct every digit >= 5 by adding 3, then
  // shift left with bit_in entering at bit 0. Result bit [BW] is the bit
  // pushed out of the top digit; bits [BW-1:0] are the new digits.
  function automatic logic [BW:0] passo_dd(input logic [BW-1:0] bcd,
                                           input logic          bit_in);
    logic [BW-1:0] ajuste;
    ajuste = bcd;
    for (int i = 0; i < DIGITOS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        ajuste[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end else begin
        ajuste[4*i +: 4] = bcd[4*i +: 4];
      end
    end
    return {ajuste, bit_in};
  endfunction

  estado_t              estado_r;
  estado_t              estado_s;
  logic [CW-1:0]        cont_r;
  logic [LARGURA-1:0]   mag_r;
  logic                 neg_r;
  logic [BW-1:0]        bcd_r;
  logic                 estouro_w_r;
  logic [BW:0]          passo_s;
  logic                 negativo_s;
  logic [LARGURA-1:0]   magnitude_s;

  logic                 ocupado_r;
  logic                 pronto_r;
  logic                 sinal_r;
  logic [BW-1:0]        digitos_r;
  logic                 estouro_r;

  // Sign and magnitude of the incoming value; the negation is modulo
  // 2^LARGURA so the most negative value maps to its correct magnitude.
  always_comb begin
    negativo_s  = 1'b0;
    magnitude_s = numero;
    if ((COM_SINAL != 0) && numero[LARGURA-1]) begin
      negativo_s  = 1'b1;
      magnitude_s = {LARGURA{1'b0}} - numero;
    end else begin
      negativo_s  = 1'b0;
      magnitude_s = numero;
    end
  end

  // Next double-dabble step from the current working digits and next bit.
  always_comb begin
    passo_s = passo_dd(bcd_r, mag_r[LARGURA-1]);
  end

  // Next-state logic.
  always_comb begin
    estado_s = estado_r;
    case (estado_r)
      OCIOSO: begin
        if (iniciar) begin
          estado_s = CONVERTE;
        end else begin
          estado_s = OCIOSO;
        end
      end
      CONVERTE: begin
        if (cont_r == CW'(1)) begin
          estado_s = CONCLUI;
        end else begin
          estado_s = CONVERTE;
        end
      end
      CONCLUI: estado_s = OCIOSO;
      default: estado_s = OCIOSO;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_r <= OCIOSO;
    end else begin
      estado_r <= estado_s;
    end
  end

  // Working registers: capture on start, one conversion step per CONVERTE edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cont_r      <= '0;
      mag_r       <= '0;
      neg_r       <= 1'b0;
      bcd_r       <= '0;
      estouro_w_r <= 1'b0;
    end else begin
      case (estado_r)
        OCIOSO: begin
          if (iniciar) begin
            cont_r      <= CW'(LARGURA);
            mag_r       <= magnitude_s;
            neg_r       <= negativo_s;
            bcd_r       <= '0;
            estouro_w_r <= 1'b0;
          end
        end
        CONVERTE: begin
          bcd_r       <= passo_s[BW-1:0];
          // Sticky: any 1 lost off the top digit means truncation.
          estouro_w_r <= estouro_w_r | passo_s[BW];
          mag_r       <= {mag_r[LARGURA-2:0], 1'b0};
          cont_r      <= cont_r - CW'(1);
        end
        default: begin
          cont_r <= cont_r;
        end
      endcase
    end
  end

  // Published outputs: loaded only on the edge leaving CONCLUI, held otherwise.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sinal_r   <= 1'b0;
      digitos_r <= '0;
      estouro_r <= 1'b0;
    end else if (estado_r == CONCLUI) begin
      sinal_r   <= neg_r;
      digitos_r <= bcd_r;
      estouro_r <= estouro_w_r;
    end else begin
      sinal_r   <= sinal_r;
      digitos_r <= digitos_r;
      estouro_r <= estouro_r;
    end
  end

  // Status flags, registered alongside the state so they track it exactly.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ocupado_r <= 1'b0;
      pronto_r  <= 1'b0;
    end else begin
      ocupado_r <= (estado_s != OCIOSO);
      pronto_r  <= (estado_r == CONCLUI);
    end
  end

  assign ocupado = ocupado_r;
  assign pronto  = pronto_r;
  assign sinal   = sinal_r;
  assign digitos = digitos_r;
  assign estouro = estouro_r;

endmodule

// File: tb/tb_bcd_n_digitos.sv
// Testbench for bcd_n_digitos: three instances (8/2/signed, 8/3/unsigned,
// defaults). Expected results come from an arithmetic model (division by 10)
// pushed into per-instance queues; a negedge monitor pops them on pronto.
module tb_bcd_n_digitos;

  typedef struct {
    logic [39:0] d;
    logic        s;
    logic        e;
  } exp_t;

  logic        clock;
  logic        reset;

  logic        iniciar_a, ocupado_a, pronto_a, sinal_a, estouro_a;
  logic [7:0]  numero_a, digitos_a;
  logic        iniciar_b, ocupado_b, pronto_b, sinal_b, estouro_b;
  logic [7:0]  numero_b;
  logic [11:0] digitos_b;
  logic        iniciar_c, ocupado_c, pronto_c, sinal_c, estouro_c;
  logic [31:0] numero_c;
  logic [39:0] digitos_c;

  int   checks;
  int   errors;
  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];
  exp_t ea, eb, ec;

  bcd_n_digitos #(.LARGURA(8), .DIGITOS(2), .COM_SINAL(1)) dut_a (
    .clock(clock), .reset(reset), .iniciar(iniciar_a), .numero(numero_a),
    .ocupado(ocupado_a), .pronto(pronto_a), .sinal(sinal_a),
    .digitos(digitos_a), .estouro(estouro_a));

  bcd_n_digitos #(.LARGURA(8), .DIGITOS(3), .COM_SINAL(0)) dut_b (
    .clock(clock), .reset(reset), .iniciar(iniciar_b), .numero(numero_b),
    .ocupado(ocupado_b), .pronto(pronto_b), .sinal(sinal_b),
    .digitos(digitos_b), .estouro(estouro_b));

  bcd_n_digitos dut_c (
    .clock(clock), .reset(reset), .iniciar(iniciar_c), .numero(numero_c),
    .ocupado(ocupado_c), .pronto(pronto_c), .sinal(sinal_c),
    .digitos(digitos_c), .estouro(estouro_c));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: sign/magnitude, then decimal digits by repeated division.
  function automatic exp_t model(input logic [63:0] num, input int lw,
                                 input int nd, input bit sgn);
    exp_t        r;
    logic [63:0] mask;
    logic [63:0] mag;
    logic [63:0] lim;
    mask = (lw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << lw) - 64'd1);
    num  = num & mask;
    r.s  = sgn && num[lw-1];
    mag  = r.s ? ((~num + 64'd1) & mask) : num;
    lim  = 64'd1;
    for (int i = 0; i < nd; i++) lim = lim * 64'd10;
    r.e = (mag >= lim);
    r.d = 40'd0;
    for (int i = 0; i < nd; i++) begin
      r.d[4*i +: 4] = 4'((mag % 64'd10));
      mag = mag / 64'd10;
    end
    return r;
  endfunction

  function automatic bit bcd_ok(input logic [39:0] d, input int nd);
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < nd; i++) if (d[4*i +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  // Scoreboard: every pronto must match the oldest pending expectation.
  always @(negedge clock) begin
    if (pronto_a) begin
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL sb_a_unexpected_pronto: got digitos=%h with no conversion pending", digitos_a);
      end else begin
        ea = qa.pop_front();
        if ({sinal_a, estouro_a, digitos_a} !== {ea.s, ea.e, ea.d[7:0]} || !bcd_ok({32'd0, digitos_a}, 2)) begin
          errors++;
          $display("FAIL sb_a: got s=%b e=%b d=%h expected s=%b e=%b d=%h",
                   sinal_a, estouro_a, digitos_a, ea.s, ea.e, ea.d[7:0]);
        end
      end
    end
    if (pronto_b) begin
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL sb_b_unexpected_pronto: got digitos=%h with no conversion pending", digitos_b);
      end else begin
        eb = qb.pop_front();
        if ({sinal_b, estouro_b, digitos_b} !== {eb.s, eb.e, eb.d[11:0]}) begin
          errors++;
          $display("FAIL sb_b: got s=%b e=%b d=%h expected s=%b e=%b d=%h",
                   sinal_b, estouro_b, digitos_b, eb.s, eb.e, eb.d[11:0]);
        end
      end
    end
    if (pronto_c) begin
      checks++;
      if (qc.size() == 0) begin
        errors++;
        $display("FAIL sb_c_unexpected_pronto: got digitos=%h with no conversion pending", digitos_c);
      end else begin
        ec = qc.pop_front();
        if ({sinal_c, estouro_c, digitos_c} !== {ec.s, ec.e, ec.d}) begin
          errors++;
          $display("FAIL sb_c: got s=%b e=%b d=%h expected s=%b e=%b d=%h",
                   sinal_c, estouro_c, digitos_c, ec.s, ec.e, ec.d);
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    iniciar_a = 1'b0; iniciar_b = 1'b0; iniciar_c = 1'b0;
    numero_a = 8'd0; numero_b = 8'd0; numero_c = 32'd0;
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({ocupado_a, pronto_a, sinal_a, estouro_a, digitos_a, ocupado_b, pronto_b, sinal_b, estouro_b, digitos_b,
         ocupado_c, pronto_c, sinal_c, estouro_c, digitos_c} !== 68'd0) begin
      errors++;
      $display("FAIL reset_outputs: got a=%h b=%h c=%h expected all zero", digitos_a, digitos_b, digitos_c);
    end
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1'b1;
  endtask

  // Full timing check on instance A: ocupado, hold, latency, pulse width.
  task automatic run_a(input logic [7:0] n);
    logic [7:0] held;
    @(negedge clock);
    iniciar_a = 1'b1; numero_a = n;
    qa.push_back(model({56'd0, n}, 8, 2, 1'b1));
    held = digitos_a;
    @(posedge clock); #1;
    iniciar_a = 1'b0; numero_a = ~n;
    checks++;
    if (ocupado_a !== 1'b1) begin
      errors++; $display("FAIL a_ocupado_start: got %b expected 1", ocupado_a);
    end
    for (int i = 1; i <= 9; i++) begin
      @(posedge clock); #1;
      checks++;
      if (i < 9) begin
        if ({ocupado_a, pronto_a, digitos_a} !== {1'b1, 1'b0, held}) begin
          errors++;
          $display("FAIL a_during_conv step %0d: got ocupado=%b pronto=%b d=%h expected 1 0 %h",
                   i, ocupado_a, pronto_a, digitos_a, held);
        end
      end else begin
        if ({ocupado_a, pronto_a} !== 2'b01) begin
          errors++;
          $display("FAIL a_latency: got ocupado=%b pronto=%b expected 0 1", ocupado_a, pronto_a);
        end
      end
    end
    @(posedge clock); #1;
    checks++;
    if (pronto_a !== 1'b0) begin
      errors++; $display("FAIL a_pronto_width: got %b expected 0", pronto_a);
    end
  endtask

  task automatic test_basic_a();
    run_a(8'd99);
    run_a(8'hF9);
    run_a(8'h80);
    run_a(8'd0);
    run_a(8'h7F);
    run_a(8'hFF);
    for (int i = 0; i < 6; i++) run_a(8'($urandom_range(0, 255)));
  endtask

  task automatic run_b(input logic [7:0] n);
    int lat;
    @(negedge clock);
    iniciar_b = 1'b1; numero_b = n;
    qb.push_back(model({56'd0, n}, 8, 3, 1'b0));
    @(posedge clock); #1;
    iniciar_b = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock); #1;
      if (pronto_b && lat == 0) lat = i;
      if (lat != 0) break;
    end
    checks++;
    if (lat != 9) begin
      errors++; $display("FAIL b_latency: got %0d edges expected 9", lat);
    end
  endtask

  task automatic test_unsigned_b();
    run_b(8'hFF);
    run_b(8'd0);
    run_b(8'd100);
    run_b(8'($urandom_range(0, 255)));
  endtask

  task automatic run_c(input logic [31:0] n);
    int lat;
    @(negedge clock);
    iniciar_c = 1'b1; numero_c = n;
    qc.push_back(model({32'd0, n}, 32, 10, 1'b1));
    @(posedge clock); #1;
    iniciar_c = 1'b0;
    lat = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clock); #1;
      if (pronto_c && lat == 0) lat = i;
      if (lat != 0) break;
    end
    checks++;
    if (lat != 33) begin
      errors++; $display("FAIL c_latency: got %0d edges expected 33", lat);
    end
  endtask

  task automatic test_defaults_c();
    run_c(32'h7FFF_FFFF);
    run_c(32'h8000_0000);
    run_c(32'd0);
    run_c(32'hFFFF_FFFF);
    run_c($urandom);
  endtask

  // A second start during CONVERTE must not create a second result.
  task automatic test_ignore_start();
    @(negedge clock);
    iniciar_a = 1'b1; numero_a = 8'd42;
    qa.push_back(model(64'd42, 8, 2, 1'b1));
    @(posedge clock); #1;
    iniciar_a = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock) begin iniciar_a = 1'b1; numero_a = 8'd5; end
    @(negedge clock) iniciar_a = 1'b0;
    repeat (20) @(posedge clock);
    #1;
    checks++;
    if ({ocupado_a, digitos_a} !== {1'b0, 8'h42}) begin
      errors++; $display("FAIL ignore_start: got ocupado=%b d=%h expected 0 42", ocupado_a, digitos_a);
    end
  endtask

  // iniciar held high across pronto starts the next conversion that cycle.
  task automatic test_back_to_back();
    int lat;
    @(negedge clock);
    iniciar_a = 1'b1; numero_a = 8'd12;
    qa.push_back(model(64'd12, 8, 2, 1'b1));
    @(posedge clock); #1;
    numero_a = 8'd34;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock); #1;
      if (pronto_a && lat == 0) lat = i;
      if (lat != 0) break;
    end
    checks++;
    if (lat != 9 || ocupado_a !== 1'b0) begin
      errors++; $display("FAIL b2b_first: got lat=%0d ocupado=%b expected 9 0", lat, ocupado_a);
    end
    qa.push_back(model(64'd34, 8, 2, 1'b1));
    @(posedge clock); #1;
    iniciar_a = 1'b0;
    checks++;
    if (ocupado_a !== 1'b1) begin
      errors++; $display("FAIL b2b_restart: got ocupado=%b expected 1", ocupado_a);
    end
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock); #1;
      if (pronto_a && lat == 0) lat = i;
      if (lat != 0) break;
    end
    checks++;
    if (lat != 9) begin
      errors++; $display("FAIL b2b_second_latency: got %0d expected 9", lat);
    end
  endtask

  // Reset mid-conversion aborts it; then a start on the first edge after
  // release is accepted.
  task automatic test_reset_abort();
    int seen;
    @(negedge clock);
    iniciar_a = 1'b1; numero_a = 8'd77;
    @(posedge clock); #1;
    iniciar_a = 1'b0;
    repeat (4) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({ocupado_a, pronto_a, sinal_a, estouro_a, digitos_a} !== 12'd0) begin
      errors++;
      $display("FAIL reset_abort_outputs: got ocupado=%b pronto=%b s=%b e=%b d=%h expected all zero",
               ocupado_a, pronto_a, sinal_a, estouro_a, digitos_a);
    end
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clock); #1;
      if (pronto_a || ocupado_a) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL reset_abort_no_pronto: got %0d active cycles expected 0", seen);
    end
    @(negedge clock) begin reset = 1'b0; iniciar_a = 1'b1; numero_a = 8'd63; end
    qa.push_back(model(64'd63, 8, 2, 1'b1));
    @(negedge clock) reset = 1'b1;
    @(posedge clock); #1;
    iniciar_a = 1'b0;
    checks++;
    if (ocupado_a !== 1'b1) begin
      errors++; $display("FAIL reset_first_edge_accept: got ocupado=%b expected 1", ocupado_a);
    end
    repeat (12) @(posedge clock);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic_a();
    test_unsigned_b();
    test_defaults_c();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    repeat (5) @(posedge clock);
    #1;
    checks++;
    if (qa.size() + qb.size() + qc.size() != 0) begin
      errors++;
      $display("FAIL pending_results: got %0d/%0d/%0d outstanding expected 0",
               qa.size(), qb.size(), qc.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
